// File: rtl/shift_add_mult_ctrl.sv
// Shift-and-add sequencer: unsigned WIDTH x WIDTH -> 2*WIDTH multiply, one
// adder pass per clock, with a start/busy/done handshake and a held product.
module shift_add_mult_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int              CW        = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   LAST_PASS = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next;

    logic [WIDTH-1:0]       r_mcand;
    logic [WIDTH-1:0]       r_mreg;
    logic [WIDTH:0]         r_acc;
    logic [CW-1:0]          r_cnt;
    logic [2*WIDTH-1:0]     r_product;
    logic                   r_busy;
    logic                   r_done;

    logic                   w_load;
    logic                   w_step;
    logic                   w_last;
    logic [WIDTH:0]         w_sum;
    logic [WIDTH:0]         w_acc_nxt;
    logic [WIDTH-1:0]       w_mreg_nxt;

    // acc[WIDTH] is always zero after a shift, so adding the full acc equals
    // adding acc[WIDTH-1:0] while keeping every bit of the register in use.
    always_comb begin
        w_sum = r_acc + {1'b0, (r_mreg[0] ? r_mcand : {WIDTH{1'b0}})};
        {w_acc_nxt, w_mreg_nxt} = {1'b0, w_sum, r_mreg[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples the pre-edge values of its neighbours.
            r_state <= w_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case leaves a signal unassigned and infers a latch.
        w_next = r_state;
        w_load = 1'b0;
        w_step = 1'b0;
        w_last = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load = 1'b1;
                    w_next = RUN;
                end
            end
            RUN: begin
                w_step = 1'b1;
                if (r_cnt == LAST_PASS) begin
                    w_last = 1'b1;
                    w_next = DONE;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // busy/done are flopped from the next state so they leave a register
    // directly, with no combinational path from start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_next == RUN);
            r_done <= (w_next == DONE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mcand <= '0;
            r_mreg  <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else if (w_load) begin
            r_mcand <= a;
            r_mreg  <= b;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else if (w_step) begin
            r_acc   <= w_acc_nxt;
            r_mreg  <= w_mreg_nxt;
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_product <= '0;
        end else if (w_last) begin
            r_product <= {w_acc_nxt[WIDTH-1:0], w_mreg_nxt};
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_product;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Directed bench for shift_add_mult_ctrl at WIDTH=4: latency, handshake,
// ignored starts, async reset abort and a back-to-back held-start sweep.
module tb_shift_add_mult_ctrl;

    localparam int W = 4;

    logic           clk;
    logic           reset;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    shift_add_mult_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drives one operation from IDLE; with noise set, start is held high with
    // a=b=7 through RUN and DONE, which must have no effect.
    task automatic run_mult(input string tag, input logic [W-1:0] ia,
                            input logic [W-1:0] ib, input logic noise);
        int             n;
        logic [2*W-1:0] exp;
        logic [2*W-1:0] held;
        exp   = (2*W)'(ia) * (2*W)'(ib);
        held  = product;
        start = 1'b1;
        a     = ia;
        b     = ib;
        @(posedge clk); #1;
        check({tag, " busy after accept"}, 32'(busy), 1);
        check({tag, " done after accept"}, 32'(done), 0);
        start = noise;
        a     = 4'd7;
        b     = 4'd7;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (!done && n < W) begin
                check({tag, " busy in run"}, 32'(busy), 1);
                check({tag, " product stable in run"}, 32'(product), 32'(held));
            end
        end while (!done && n < 12);
        check({tag, " done latency"}, n, W);
        check({tag, " product"}, 32'(product), 32'(exp));
        check({tag, " busy with done"}, 32'(busy), 0);
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, " done one cycle"}, 32'(done), 0);
        check({tag, " busy in idle"}, 32'(busy), 0);
        @(posedge clk); #1;
        check({tag, " no retrigger"}, 32'(busy), 0);
        check({tag, " product held"}, 32'(product), 32'(exp));
    endtask

    initial begin
        int n;
        int last_accept;

        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #1;
        check("reset busy", 32'(busy), 0);
        check("reset done", 32'(done), 0);
        check("reset product", 32'(product), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        check("idle busy", 32'(busy), 0);

        run_mult("t1 3x5", 4'd3, 4'd5, 1'b0);
        run_mult("t2 15x15", 4'd15, 4'd15, 1'b0);
        run_mult("t3 0x11", 4'd0, 4'd11, 1'b0);
        run_mult("t3 9x0", 4'd9, 4'd0, 1'b0);
        run_mult("t4 2x3 ignore", 4'd2, 4'd3, 1'b1);

        // Reset two edges into a run clears everything without a clock edge.
        start = 1'b1;
        a     = 4'd6;
        b     = 4'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("t5 abort busy", 32'(busy), 0);
        check("t5 abort done", 32'(done), 0);
        check("t5 abort product", 32'(product), 0);
        @(posedge clk); #2;
        reset = 1'b0;
        @(posedge clk); #1;
        check("t5 idle after abort", 32'(busy), 0);
        run_mult("t5 6x7", 4'd6, 4'd7, 1'b0);

        // Held start: operands for the next pass are presented right after
        // each acceptance, so accepts land WIDTH+2 cycles apart.
        start       = 1'b1;
        a           = 4'd1;
        b           = 4'd13;
        last_accept = 0;
        for (int i = 1; i <= 15; i++) begin
            n = 0;
            do begin
                @(posedge clk); #1;
                n++;
            end while (!busy && n < 12);
            check("t6 accepted", 32'(busy), 1);
            if (i > 1) check("t6 spacing", cyc - last_accept, W + 2);
            last_accept = cyc;
            if (i == 15) start = 1'b0;
            else a = W'(i + 1);
            n = 0;
            do begin
                @(posedge clk); #1;
                n++;
            end while (!done && n < 12);
            check("t6 latency", n, W);
            check("t6 product", 32'(product), 32'(i * 13));
        end
        repeat (2) @(posedge clk);
        #1;
        check("t6 idle at end", 32'(busy), 0);
        check("t6 final product", 32'(product), 195);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
